// File: rtl/osc_pkg.sv
// Shared encodings for the multiwave oscillator, plus the elaboration-time
// generator that fills the quarter-sine ROM.
package osc_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_TRI    = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_SQUARE = 2'd3
    } osc_mode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } osc_state_e;

    localparam int OSC_LATENCY = 3;

    localparam longint PI_Q30 = 64'sd3373259426;

    // Entry idx is A*sin(pi*(2*idx+1)/(4*N)), evaluated in Q30 with a Taylor series.
    function automatic longint quarterSineEntry(input int idx, input int tableBits,
                                                input int sampleBits);
        longint x;
        longint term;
        longint acc;
        longint amp;
        longint val;
        x   = (PI_Q30 * longint'(2 * idx + 1)) / (longint'(4) << tableBits);
        term = x;
        acc  = x;
        for (int k = 1; k <= 7; k++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        amp = (longint'(1) << (sampleBits - 1)) - 1;
        val = (acc * amp + (longint'(1) << 29)) >>> 30;
        if (val > amp) val = amp;
        if (val < 0) val = 0;
        return val;
    endfunction

endpackage

// File: rtl/multiwave_oscillator_quarter_sine_rom.sv
// Registered-read quarter-sine ROM; contents are derived from BITSIZE/TABLESIZE
// at elaboration so every parameter set gets its own table.
module quarter_sine_rom
    import osc_pkg::*;
#(
    parameter int BITSIZE   = 24,
    parameter int TABLESIZE = 9
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [TABLESIZE-1:0] addr_i,
    output logic [BITSIZE-1:0]   data_o
);

    localparam int DEPTH = 1 << TABLESIZE;

    logic [BITSIZE-1:0] romTable [DEPTH];
    logic [BITSIZE-1:0] data_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        localparam longint ENTRY = quarterSineEntry(i, TABLESIZE, BITSIZE);
        assign romTable[i] = BITSIZE'(ENTRY);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= romTable[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/multiwave_oscillator.sv
// Phase-accumulator oscillator (sine/triangle/saw/square) with a zero-crossing start/stop gate.
// Define OSC_HARDSYNC_EN to add a 'sync' input that hard-resets the phase.
module multiwave_oscillator
    import osc_pkg::*;
#(
    parameter int BITSIZE   = 24,
    parameter int PHASESIZE = 16,
    parameter int TABLESIZE = 9
) (
    input  logic                 lrclk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [PHASESIZE-1:0] freq,
    input  logic [PHASESIZE-1:0] phase_offset,
    input  logic [1:0]           mode,
`ifdef OSC_HARDSYNC_EN
    input  logic                 sync,
`endif
    output logic [BITSIZE-1:0]   out,
    output logic                 active
);

    localparam int PS = PHASESIZE;
    localparam logic [BITSIZE-1:0] SQUARE_POS = {1'b0, {(BITSIZE-1){1'b1}}};
    localparam logic [BITSIZE-1:0] SQUARE_NEG = -SQUARE_POS;

    osc_state_e           state_q;
    logic [PS-1:0]        phase_q;
    logic                 active_q;
    logic [PS:0]          phaseSum_d;
    logic                 syncReq_d;

    logic [PS-1:0]        lookupPhase_d;
    logic [TABLESIZE-1:0] tableIndex_d;
    logic [PS-1:0]        s1Phase_q;
    logic [TABLESIZE-1:0] s1Index_q;
    osc_mode_e            s1Mode_q;
    logic                 s1Valid_q;

    logic [PS-3:0]        triMag_d;
    logic [BITSIZE-2:0]   triJustified_d;
    logic [BITSIZE-1:0]   sawJustified_d;
    logic [BITSIZE-1:0]   romData;
    logic [BITSIZE-1:0]   s2Tri_q;
    logic [BITSIZE-1:0]   s2Saw_q;
    logic [BITSIZE-1:0]   s2Square_q;
    logic                 s2Negate_q;
    osc_mode_e            s2Mode_q;
    logic                 s2Valid_q;

    logic [BITSIZE-1:0]   sample_d;
    logic [BITSIZE-1:0]   out_q;

`ifdef OSC_HARDSYNC_EN
    assign syncReq_d = sync;
`else
    assign syncReq_d = 1'b0;
`endif

    assign phaseSum_d = {1'b0, phase_q} + {1'b0, freq};

    // Gate FSM: stopping only completes on a phase wrap so the output never clicks.
    always_ff @(posedge lrclk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    phase_q <= '0;
                    if (enable) begin
                        state_q  <= RUN;
                        active_q <= 1'b1;
                    end
                end
                RUN: begin
                    phase_q <= syncReq_d ? '0 : phaseSum_d[PS-1:0];
                    if (!enable) begin
                        state_q <= STOPPING;
                    end
                end
                STOPPING: begin
                    if (enable) begin
                        state_q <= RUN;
                        phase_q <= phaseSum_d[PS-1:0];
                    end else if (syncReq_d || freq == '0 || phaseSum_d[PS]) begin
                        state_q  <= IDLE;
                        phase_q  <= '0;
                        active_q <= 1'b0;
                    end else begin
                        phase_q <= phaseSum_d[PS-1:0];
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    phase_q  <= '0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign lookupPhase_d = phase_q + phase_offset;
    assign tableIndex_d  = lookupPhase_d[PS-2] ? ~lookupPhase_d[PS-3 -: TABLESIZE]
                                               :  lookupPhase_d[PS-3 -: TABLESIZE];

    always_ff @(posedge lrclk) begin
        if (reset) begin
            s1Phase_q <= '0;
            s1Index_q <= '0;
            s1Mode_q  <= MODE_SINE;
            s1Valid_q <= 1'b0;
        end else begin
            s1Phase_q <= lookupPhase_d;
            s1Index_q <= tableIndex_d;
            s1Mode_q  <= osc_mode_e'(mode);
            s1Valid_q <= (state_q != IDLE);
        end
    end

    quarter_sine_rom #(
        .BITSIZE   (BITSIZE),
        .TABLESIZE (TABLESIZE)
    ) u_rom (
        .clk_i   (lrclk),
        .reset_i (reset),
        .addr_i  (s1Index_q),
        .data_o  (romData)
    );

    assign triMag_d = s1Phase_q[PS-2] ? ~s1Phase_q[PS-3:0] : s1Phase_q[PS-3:0];

    // Left-justify: zero-pad below when the source is narrower, else keep the top bits.
    if (PS - 2 < BITSIZE - 1) begin : g_triPad
        assign triJustified_d = {triMag_d, {(BITSIZE - 1 - (PS - 2)){1'b0}}};
    end else begin : g_triTrim
        assign triJustified_d = triMag_d[PS-3 -: BITSIZE-1];
    end

    if (PS < BITSIZE) begin : g_sawPad
        assign sawJustified_d = {s1Phase_q, {(BITSIZE - PS){1'b0}}};
    end else begin : g_sawTrim
        assign sawJustified_d = s1Phase_q[PS-1 -: BITSIZE];
    end

    always_ff @(posedge lrclk) begin
        if (reset) begin
            s2Tri_q    <= '0;
            s2Saw_q    <= '0;
            s2Square_q <= '0;
            s2Negate_q <= 1'b0;
            s2Mode_q   <= MODE_SINE;
            s2Valid_q  <= 1'b0;
        end else begin
            s2Tri_q    <= {1'b0, triJustified_d};
            s2Saw_q    <= sawJustified_d;
            s2Square_q <= s1Phase_q[PS-1] ? SQUARE_NEG : SQUARE_POS;
            s2Negate_q <= s1Phase_q[PS-1];
            s2Mode_q   <= s1Mode_q;
            s2Valid_q  <= s1Valid_q;
        end
    end

    always_comb begin
        sample_d = '0;
        case (s2Mode_q)
            MODE_SINE:   sample_d = s2Negate_q ? -romData : romData;
            MODE_TRI:    sample_d = s2Negate_q ? -s2Tri_q : s2Tri_q;
            MODE_SAW:    sample_d = s2Saw_q;
            MODE_SQUARE: sample_d = s2Square_q;
            default:     sample_d = '0;
        endcase
    end

    always_ff @(posedge lrclk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= s2Valid_q ? sample_d : '0;
        end
    end

    assign out    = out_q;
    assign active = active_q;

endmodule

// File: tb/tb_multiwave_oscillator.sv
// Self-checking bench: per-cycle scoreboard fed by a reference model, a vector table
// for the sine/square patterns, and hand-written gate and mode-switch sequences.
module tb_multiwave_oscillator;
    import osc_pkg::*;

    localparam int AMP = 8388607;

    logic        lrclk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] freq;
    logic [15:0] phase_offset;
    logic [1:0]  mode;
    logic [23:0] out;
    logic        active;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int value;
        int tol;
    } sb_entry_t;

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] freq;
        logic [15:0] offset;
        logic [1:0]  mode;
        int          expOut;
        int          expActive;
    } vec_t;

    sb_entry_t sbQueue[$];
    int        modelState = 0;
    int        modelPhase = 0;

    multiwave_oscillator #(
        .BITSIZE   (24),
        .PHASESIZE (16),
        .TABLESIZE (9)
    ) dut (
        .lrclk        (lrclk),
        .reset        (reset),
        .enable       (enable),
        .freq         (freq),
        .phase_offset (phase_offset),
        .mode         (mode),
`ifdef OSC_HARDSYNC_EN
        .sync         (1'b0),
`endif
        .out          (out),
        .active       (active)
    );

    always #5 lrclk = ~lrclk;

    function automatic int sineRef(input int idx);
        real angle;
        angle = 3.14159265358979 * real'(2 * idx + 1) / 2048.0;
        return int'($floor(real'(AMP) * $sin(angle) + 0.5));
    endfunction

    function automatic int expSample(input int ph, input int off, input int md, input bit tag);
        int p;
        int idx;
        int mag;
        int v;
        logic [23:0] r;
        if (!tag) return 0;
        p = (ph + off) & 32'hFFFF;
        case (md)
            0: begin
                idx = (p >> 5) & 511;
                if ((p & 32'h4000) != 0) idx = 511 - idx;
                mag = sineRef(idx);
                v = ((p & 32'h8000) != 0) ? -mag : mag;
            end
            1: begin
                mag = p & 32'h3FFF;
                if ((p & 32'h4000) != 0) mag = 32'h3FFF - mag;
                mag = mag << 9;
                v = ((p & 32'h8000) != 0) ? -mag : mag;
            end
            2: begin
                r = 24'(p) << 8;
                v = int'($signed(r));
            end
            default: v = ((p & 32'h8000) != 0) ? -AMP : AMP;
        endcase
        return v;
    endfunction

    task automatic modelEdge();
        int sum;
        if (reset) begin
            modelState = 0;
            modelPhase = 0;
            return;
        end
        sum = modelPhase + int'(freq);
        case (modelState)
            0: begin
                modelPhase = 0;
                if (enable) modelState = 1;
            end
            1: begin
                modelPhase = sum % 65536;
                if (!enable) modelState = 2;
            end
            default: begin
                if (enable) begin
                    modelState = 1;
                    modelPhase = sum % 65536;
                end else if (freq == 16'h0 || sum >= 65536) begin
                    modelState = 0;
                    modelPhase = 0;
                end else begin
                    modelPhase = sum;
                end
            end
        endcase
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected,
                               input int tol);
        int diff;
        diff = actual - expected;
        checks++;
        if (diff > tol || diff < -tol) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%06h), expected %0d (0x%06h)",
                     name, actual, actual[23:0], expected, expected[23:0]);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [15:0] f,
                                 input logic [15:0] off, input logic [1:0] md);
        reset        = rst;
        enable       = en;
        freq         = f;
        phase_offset = off;
        mode         = md;
    endtask

    // One lrclk edge: push the model's prediction, advance the model, then compare.
    task automatic tick(input string name);
        sb_entry_t e;
        if (!reset) begin
            e.value = expSample(modelPhase, int'(phase_offset), int'(mode), modelState != 0);
            e.tol   = (mode == 2'd0) ? 2 : 0;
            sbQueue.push_back(e);
        end
        modelEdge();
        @(posedge lrclk);
        #1;
        if (reset) begin
            sbQueue.delete();
            e.value = 0;
            e.tol   = 0;
            sbQueue.push_back(e);
            sbQueue.push_back(e);
            checkOutput({name, " out in reset"}, int'($signed(out)), 0, 0);
            checkOutput({name, " active in reset"}, int'(active), 0, 0);
        end else begin
            if (sbQueue.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL %s scoreboard: got empty queue, expected a pending sample", name);
            end else begin
                e = sbQueue.pop_front();
                checkOutput({name, " sb out"}, int'($signed(out)), e.value, e.tol);
            end
            checkOutput({name, " sb active"}, int'(active), (modelState != 0) ? 1 : 0, 0);
        end
    endtask

    vec_t vectors[22];
    int   edges;

    initial begin
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 2'd0);

        vectors[0] = '{1'b1, 1'b1, 16'h2000, 16'h0, 2'd3, 0, 0};
        for (int i = 1; i <= 3; i++)  vectors[i] = '{1'b0, 1'b1, 16'h2000, 16'h0, 2'd3, 0, 1};
        for (int i = 4; i <= 7; i++)  vectors[i] = '{1'b0, 1'b1, 16'h2000, 16'h0, 2'd3, AMP, 1};
        for (int i = 8; i <= 11; i++) vectors[i] = '{1'b0, 1'b1, 16'h2000, 16'h0, 2'd3, -AMP, 1};
        vectors[12] = '{1'b0, 1'b1, 16'h2000, 16'h0, 2'd3, AMP, 1};
        vectors[13] = '{1'b1, 1'b1, 16'h4000, 16'h0, 2'd0, 0, 0};
        for (int i = 14; i <= 16; i++) vectors[i] = '{1'b0, 1'b1, 16'h4000, 16'h0, 2'd0, 0, 1};
        vectors[17] = '{1'b0, 1'b1, 16'h4000, 16'h0, 2'd0, 12868, 1};
        vectors[18] = '{1'b0, 1'b1, 16'h4000, 16'h0, 2'd0, 8388597, 1};
        vectors[19] = '{1'b0, 1'b1, 16'h4000, 16'h0, 2'd0, -12868, 1};
        vectors[20] = '{1'b0, 1'b1, 16'h4000, 16'h0, 2'd0, -8388597, 1};
        vectors[21] = '{1'b0, 1'b1, 16'h4000, 16'h0, 2'd0, 12868, 1};

        @(negedge lrclk);
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vectors[i].rst, vectors[i].en, vectors[i].freq,
                          vectors[i].offset, vectors[i].mode);
            tick($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d out", i), int'($signed(out)), vectors[i].expOut,
                        (vectors[i].mode == 2'd0) ? 2 : 0);
            checkOutput($sformatf("vec%0d active", i), int'(active), vectors[i].expActive, 0);
        end

        // Stop gate: drop enable at phase 0x3000, expect IDLE on the wrap 13 edges later.
        applyStimulus(1'b1, 1'b1, 16'h1000, 16'h0, 2'd2);
        tick("stopRst");
        applyStimulus(1'b0, 1'b1, 16'h1000, 16'h0, 2'd2);
        repeat (4) tick("stopRun");
        enable = 1'b0;
        edges = 0;
        while (active && edges < 40) begin
            tick("stopDrain");
            edges++;
        end
        checkOutput("stop edges to idle", edges, 13, 0);
        tick("stopTail");
        checkOutput("stop sample before idle", int'($signed(out)), int'($signed(24'hE00000)), 0);
        tick("stopTail");
        checkOutput("stop last sample", int'($signed(out)), int'($signed(24'hF00000)), 0);
        tick("stopTail");
        checkOutput("stop out zero after idle tag", int'($signed(out)), 0, 0);

        // Re-enable while STOPPING at phase 0x8000: phase continues, no restart.
        applyStimulus(1'b1, 1'b1, 16'h1000, 16'h0, 2'd2);
        tick("reRst");
        applyStimulus(1'b0, 1'b1, 16'h1000, 16'h0, 2'd2);
        repeat (4) tick("reRun");
        enable = 1'b0;
        repeat (5) tick("reStopping");
        checkOutput("re active while stopping", int'(active), 1, 0);
        enable = 1'b1;
        tick("reEnable");
        checkOutput("re active after enable", int'(active), 1, 0);
        repeat (3) tick("reRun2");
        checkOutput("re phase continues 0x9000", int'($signed(out)), int'($signed(24'h900000)), 0);
        for (int i = 0; i < 10; i++) begin
            tick("reWrap");
            checkOutput($sformatf("re active wrap %0d", i), int'(active), 1, 0);
        end

        // Saw at constant phase, then a mode switch that lands after the pipeline latency.
        applyStimulus(1'b1, 1'b1, 16'h0, 16'h8000, 2'd2);
        tick("modeRst");
        applyStimulus(1'b0, 1'b1, 16'h0, 16'h8000, 2'd2);
        repeat (6) tick("modeSaw");
        checkOutput("saw constant 0x800000", int'($signed(out)), int'($signed(24'h800000)), 0);
        mode = 2'd1;
        for (int i = 1; i < OSC_LATENCY; i++) begin
            tick("modeSwitch");
            checkOutput($sformatf("saw holds %0d", i), int'($signed(out)),
                        int'($signed(24'h800000)), 0);
        end
        tick("modeSwitch");
        checkOutput("triangle zero at 0x8000", int'($signed(out)), 0, 0);

        // Mid-operation reset clears the output on the same edge.
        applyStimulus(1'b0, 1'b1, 16'h0321, 16'h1234, 2'd1);
        repeat (8) tick("midRun");
        reset = 1'b1;
        tick("midReset");
        checkOutput("mid reset out", int'($signed(out)), 0, 0);
        checkOutput("mid reset active", int'(active), 0, 0);
        reset = 1'b0;

        // Randomised traffic checked only through the scoreboard.
        for (int i = 0; i < 400; i++) begin
            if ((i % 8) == 0) mode = 2'($urandom_range(0, 3));
            if ((i % 16) == 0) phase_offset = 16'($urandom_range(0, 65535));
            if ((i % 4) == 0) begin
                if ($urandom_range(0, 3) == 0) freq = 16'h0;
                else if ($urandom_range(0, 1) == 0) freq = 16'($urandom_range(1, 4095));
                else freq = 16'($urandom_range(1, 65535));
            end
            enable = ($urandom_range(0, 3) != 0);
            reset  = ($urandom_range(0, 59) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
